// File: rtl/bisr_pkg.sv
// Shared state encoding and sizing helpers for the BISR weight-allocation controller.
package bisr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENVM    = 3'd1,
      ST_START   = 3'd2,
      ST_LOAD    = 3'd3,
      ST_CHECK   = 3'd4,
      ST_PRELOAD = 3'd5
   } state_e;

   localparam int FAIL_CNT_WIDTH_DEF = 8;

   // Row address width; a one-row tile still gets a 1-bit address.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bisr_alloc_controller_if.sv
// Weight-buffer and allocation-block signals of the BISR controller.
// master = controller side; slave = weight buffer / allocation block side.
interface bisr_alloc_controller_if
   import bisr_pkg::*;
#(
   parameter int SYSTOLIC_SIZE = 8,
   parameter int WEIGHT_WIDTH  = 8,
   parameter int ADDR_WIDTH    = addr_width(SYSTOLIC_SIZE)
);

   logic                                  wbuf_valid;
   logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] wbuf_data;
   logic                                  wbuf_ready;
   logic                                  envm_wr_en;
   logic                                  weight_start;
   logic                                  weight_valid;
   logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] input_weights;
   logic [ADDR_WIDTH-1:0]                 read_addr;
   logic                                  recovery_done;
   logic                                  recovery_success;

   modport master (
      input  wbuf_valid, wbuf_data, recovery_done, recovery_success,
      output wbuf_ready, envm_wr_en, weight_start, weight_valid, input_weights, read_addr
   );

   modport slave (
      output wbuf_valid, wbuf_data, recovery_done, recovery_success,
      input  wbuf_ready, envm_wr_en, weight_start, weight_valid, input_weights, read_addr
   );

endinterface

// File: rtl/bisr_alloc_controller.sv
// Sequences fault-map load, one weight-tile stream, recovery check and systolic preload.
// Latency layer_start->layer_done 2*SYSTOLIC_SIZE+3 cycles unstalled; LOAD waits on wbuf_valid indefinitely.
module bisr_alloc_controller
   import bisr_pkg::*;
#(
   parameter int SYSTOLIC_SIZE  = 8,
   parameter int WEIGHT_WIDTH   = 8,
   parameter int ADDR_WIDTH     = addr_width(SYSTOLIC_SIZE),
   parameter int DONE_TIMEOUT   = 15,
   parameter int FAIL_CNT_WIDTH = FAIL_CNT_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      envm_load,
   input  logic                      layer_start,
   bisr_alloc_controller_if.master   bus,
   output logic                      sa_weight_load,
   output logic                      busy,
   output logic                      layer_done,
   output logic                      recovery_fail,
   output logic [FAIL_CNT_WIDTH-1:0] fail_count
);

   localparam int                    TO_WIDTH  = $clog2(DONE_TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
   localparam logic [TO_WIDTH-1:0]   LAST_WAIT = TO_WIDTH'(DONE_TIMEOUT - 1);

   state_e                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     row_cnt_q, row_cnt_d;
   logic [TO_WIDTH-1:0]       timeout_q, timeout_d;
   logic [ADDR_WIDTH-1:0]     read_addr_q, read_addr_d;
   logic [FAIL_CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
   logic                      layer_done_q, layer_done_d;
   logic                      recovery_fail_q, recovery_fail_d;
   logic                      envm_wr_en_q, weight_start_q, wbuf_ready_q;
   logic                      sa_weight_load_q, busy_q;

   always_comb begin
      state_d         = state_q;
      row_cnt_d       = row_cnt_q;
      timeout_d       = timeout_q;
      read_addr_d     = read_addr_q;
      fail_cnt_d      = fail_cnt_q;
      layer_done_d    = 1'b0;
      recovery_fail_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (envm_load)        state_d = ST_ENVM;
            else if (layer_start) state_d = ST_START;
         end
         ST_ENVM:  state_d = ST_IDLE;
         ST_START: begin
            row_cnt_d = '0;
            state_d   = ST_LOAD;
         end
         ST_LOAD: begin
            if (bus.wbuf_valid) begin
               if (row_cnt_q == LAST_ROW) begin
                  timeout_d = '0;
                  state_d   = ST_CHECK;
               end else begin
                  row_cnt_d = row_cnt_q + 1'b1;
               end
            end
         end
         ST_CHECK: begin
            // A late done on the final wait cycle still wins over the timeout.
            if (bus.recovery_done && bus.recovery_success) begin
               read_addr_d = '0;
               state_d     = ST_PRELOAD;
            end else if (bus.recovery_done || timeout_q == LAST_WAIT) begin
               recovery_fail_d = 1'b1;
               if (!(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + 1'b1;
               state_d = ST_IDLE;
            end else begin
               timeout_d = timeout_q + 1'b1;
            end
         end
         ST_PRELOAD: begin
            if (read_addr_q == LAST_ROW) begin
               read_addr_d  = '0;
               layer_done_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               read_addr_d = read_addr_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         row_cnt_q        <= '0;
         timeout_q        <= '0;
         read_addr_q      <= '0;
         fail_cnt_q       <= '0;
         layer_done_q     <= 1'b0;
         recovery_fail_q  <= 1'b0;
         envm_wr_en_q     <= 1'b0;
         weight_start_q   <= 1'b0;
         wbuf_ready_q     <= 1'b0;
         sa_weight_load_q <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         row_cnt_q        <= row_cnt_d;
         timeout_q        <= timeout_d;
         read_addr_q      <= read_addr_d;
         fail_cnt_q       <= fail_cnt_d;
         layer_done_q     <= layer_done_d;
         recovery_fail_q  <= recovery_fail_d;
         envm_wr_en_q     <= (state_d == ST_ENVM);
         weight_start_q   <= (state_d == ST_START);
         wbuf_ready_q     <= (state_d == ST_LOAD);
         sa_weight_load_q <= (state_d == ST_PRELOAD);
         busy_q           <= (state_d != ST_IDLE);
      end
   end

   // Row data passes straight through; zeroed when no row is being handed over.
   assign bus.weight_valid  = wbuf_ready_q && bus.wbuf_valid;
   assign bus.input_weights = bus.weight_valid ? bus.wbuf_data : '0;
   assign bus.wbuf_ready    = wbuf_ready_q;
   assign bus.envm_wr_en    = envm_wr_en_q;
   assign bus.weight_start  = weight_start_q;
   assign bus.read_addr     = read_addr_q;
   assign sa_weight_load    = sa_weight_load_q;
   assign busy              = busy_q;
   assign layer_done        = layer_done_q;
   assign recovery_fail     = recovery_fail_q;
   assign fail_count        = fail_cnt_q;

endmodule
